// File: rtl/noc_pkg.sv
// Shared types for the NoC switch: flit type codes and switch FSM states.
package noc_pkg;
    localparam int TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        DATA    = 2'd0,
        CTRL    = 2'd1,
        RSVD    = 2'd2,
        INVALID = 2'd3
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } sw_state_e;
endpackage

// File: rtl/noc_port_fifo.sv
// Generic synchronous FIFO with a separate occupancy count.
// Latency: write at cycle N is visible on rd_data/!empty at N+1 (no bypass).
// Backpressure: full blocks writes; reads on empty are ignored.
module noc_port_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    // Empty reads as zero so the port output is clean after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/noc_switch.sv
// Wormhole packet switch: one source, NUM_PORTS output FIFOs, invalid-packet drop.
// Latency: accepted flit appears on out_valid/out_flit of its port one cycle later.
// Backpressure: src_ready drops while the targeted port FIFO is full; dropped packets never stall.
module noc_switch
    import noc_pkg::*;
#(
    parameter int  NUM_PORTS  = 4,
    parameter int  PAYLOAD_W  = 8,
    parameter int  FIFO_DEPTH = 4,
    parameter int  CNT_W      = 8,
    localparam int DST_W      = $clog2(NUM_PORTS),
    localparam int FLIT_W     = DST_W + TYPE_W + PAYLOAD_W + 1,
    localparam int OUT_W      = TYPE_W + PAYLOAD_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_valid,
    input  logic [FLIT_W-1:0]          src_flit,
    output logic                       src_ready,
    output logic [NUM_PORTS-1:0]       out_valid,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [NUM_PORTS*OUT_W-1:0] out_flit,
    output logic                       invalid_packet,
    output logic [CNT_W-1:0]           drop_count
);
    sw_state_e            state, state_nxt;
    logic [DST_W-1:0]     lock_dst, lock_nxt;
    logic [NUM_PORTS-1:0] full, empty, wr_en;
    logic [DST_W-1:0]     head_dst;
    flit_type_e           head_type;
    logic                 head_eop;
    logic                 accept;
    logic                 inv_hit;

    assign head_dst  = src_flit[FLIT_W-1 -: DST_W];
    assign head_type = flit_type_e'(src_flit[PAYLOAD_W+1 +: TYPE_W]);
    assign head_eop  = src_flit[0];
    assign accept    = src_valid && src_ready;
    assign out_valid = ~empty;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_dst;
        src_ready = 1'b0;
        wr_en     = '0;
        inv_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (head_type == INVALID) begin
                    src_ready = 1'b1;
                    if (accept) begin
                        inv_hit = 1'b1;
                        if (!head_eop) state_nxt = DROP;
                    end
                end else begin
                    src_ready = !full[head_dst];
                    if (accept) begin
                        wr_en[head_dst] = 1'b1;
                        if (!head_eop) begin
                            lock_nxt  = head_dst;
                            state_nxt = ROUTE;
                        end
                    end
                end
            end
            ROUTE: begin
                // Body/tail flits follow the locked route; their dst/type bits are don't-care.
                src_ready = !full[lock_dst];
                if (accept) begin
                    wr_en[lock_dst] = 1'b1;
                    if (head_eop) state_nxt = IDLE;
                end
            end
            DROP: begin
                src_ready = 1'b1;
                if (accept && head_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lock_dst       <= '0;
            invalid_packet <= 1'b0;
            drop_count     <= '0;
        end else begin
            state          <= state_nxt;
            lock_dst       <= lock_nxt;
            invalid_packet <= inv_hit;
            if (inv_hit && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        noc_port_fifo #(
            .WIDTH (OUT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[g]),
            .wr_data (src_flit[OUT_W-1:0]),
            .full    (full[g]),
            .rd_en   (out_ready[g]),
            .rd_data (out_flit[g*OUT_W +: OUT_W]),
            .empty   (empty[g])
        );
    end
endmodule

// File: tb/tb_noc_switch.sv
// Randomised and directed bench for noc_switch against a packet-level queue model.
module tb_noc_switch;
    localparam int NP = 4;
    localparam int PW = 8;
    localparam int FD = 4;
    localparam int CW = 8;
    localparam int FW = 13;
    localparam int OW = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           src_valid = 1'b0;
    logic [FW-1:0]  src_flit = '0;
    logic           src_ready;
    logic [NP-1:0]  out_valid;
    logic [NP-1:0]  out_ready = '0;
    logic [NP*OW-1:0] out_flit;
    logic           invalid_packet;
    logic [CW-1:0]  drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: per-port queues of expected output words plus packet mode.
    logic [OW-1:0] mq [NP][$];
    int   m_mode = 0;   // 0 expect head, 1 forwarding to m_lock, 2 discarding
    int   m_lock = 0;
    int   m_drop = 0;
    logic m_inv  = 1'b0;

    noc_switch #(.NUM_PORTS(NP), .PAYLOAD_W(PW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_flit       (src_flit),
        .src_ready      (src_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_flit       (out_flit),
        .invalid_packet (invalid_packet),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input int dst, input int typ, input int pl, input int eop);
        logic [1:0] d;
        logic [1:0] t;
        logic [7:0] p;
        d = 2'(dst);
        t = 2'(typ);
        p = 8'(pl);
        return {d, t, p, eop[0]};
    endfunction

    function automatic logic model_ready();
        int dst;
        dst = int'(src_flit[12:11]);
        if (m_mode == 2) return 1'b1;
        if (m_mode == 1) return mq[m_lock].size() < FD;
        if (src_flit[10:9] == 2'd3) return 1'b1;
        return mq[dst].size() < FD;
    endfunction

    function automatic logic [NP-1:0] model_vld();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = (mq[i].size() != 0);
        return v;
    endfunction

    task automatic step();
        logic          acc;
        logic [NP-1:0] pop;
        logic [FW-1:0] f;
        logic          was_rst;
        int            dst;
        was_rst = rst;
        acc = src_valid && model_ready();
        f   = src_flit;
        for (int i = 0; i < NP; i++) pop[i] = out_ready[i] && (mq[i].size() != 0);
        @(posedge clk);
        #1;
        m_inv = 1'b0;
        if (was_rst) begin
            for (int i = 0; i < NP; i++) mq[i].delete();
            m_mode = 0;
            m_drop = 0;
        end else begin
            for (int i = 0; i < NP; i++) if (pop[i]) void'(mq[i].pop_front());
            if (acc) begin
                dst = int'(f[12:11]);
                case (m_mode)
                    0: begin
                        if (f[10:9] == 2'd3) begin
                            m_inv = 1'b1;
                            if (m_drop < 255) m_drop++;
                            if (!f[0]) m_mode = 2;
                        end else begin
                            mq[dst].push_back(f[OW-1:0]);
                            if (!f[0]) begin
                                m_mode = 1;
                                m_lock = dst;
                            end
                        end
                    end
                    1: begin
                        mq[m_lock].push_back(f[OW-1:0]);
                        if (f[0]) m_mode = 0;
                    end
                    default: if (f[0]) m_mode = 0;
                endcase
            end
        end
    endtask

    task automatic do_reset();
        src_valid = 1'b0;
        out_ready = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL reset_out_flit got %h want 0", out_flit); end
        checks++; if (invalid_packet !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", invalid_packet); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        src_flit = mk(0, 0, 8'h12, 1);
        #1;
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready got %b want 1", src_ready); end
    endtask

    task automatic test_single_flit();
        out_ready = '0;
        src_flit  = 13'h114B;
        src_valid = 1'b1;
        #1;
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", src_ready); end
        step();
        src_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_out_valid got %b want 0100", out_valid); end
        checks++; if (out_flit[2*OW +: OW] !== 11'h14B) begin errors++; $display("FAIL single_out_flit got %h want 14b", out_flit[2*OW +: OW]); end
    endtask

    task automatic test_wormhole();
        logic [OW-1:0] exp_w [3];
        logic [FW-1:0] pkt [3];
        pkt[0] = mk(1, 0, 8'h11, 0);
        pkt[1] = mk(3, 1, 8'h22, 0);
        pkt[2] = mk(3, 0, 8'h33, 1);
        for (int i = 0; i < 3; i++) exp_w[i] = pkt[i][OW-1:0];
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            src_flit  = pkt[i];
            src_valid = 1'b1;
            #1;
            step();
        end
        src_valid = 1'b0;
        checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL worm_out_valid got %b want 0110", out_valid); end
        out_ready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_flit[OW +: OW] !== exp_w[i]) begin errors++; $display("FAIL worm_order[%0d] got %h want %h", i, out_flit[OW +: OW], exp_w[i]); end
            step();
        end
        out_ready = '0;
        checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL worm_drained got %b want 0", out_valid[1]); end
        // A fresh head must route by its own dst, proving the FSM returned to idle.
        src_flit  = mk(3, 0, 8'h44, 1);
        src_valid = 1'b1;
        #1;
        step();
        src_valid = 1'b0;
        checks++; if (out_valid !== 4'b1100) begin errors++; $display("FAIL worm_idle_route got %b want 1100", out_valid); end
    endtask

    task automatic test_invalid_drop();
        logic [FW-1:0] pkt [3];
        do_reset();
        pkt[0] = mk(0, 3, 8'hAA, 0);
        pkt[1] = mk(1, 0, 8'hBB, 0);
        pkt[2] = mk(2, 0, 8'hCC, 1);
        for (int i = 0; i < 3; i++) begin
            src_flit  = pkt[i];
            src_valid = 1'b1;
            #1;
            checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d] got %b want 1", i, src_ready); end
            step();
            checks++; if (invalid_packet !== (i == 0)) begin errors++; $display("FAIL drop_pulse[%0d] got %b want %b", i, invalid_packet, i == 0); end
        end
        src_valid = 1'b0;
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_count got %0d want 1", drop_count); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drop_no_write got %b want 0000", out_valid); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_flit  = mk(0, 0, i, 1);
            src_valid = 1'b1;
            #1;
            checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d] got %b want 1", i, src_ready); end
            step();
        end
        src_flit = mk(0, 0, 4, 1);
        #1;
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", src_ready); end
        step();
        out_ready = 4'b0001;
        #1;
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got %b want 0", src_ready); end
        step();
        out_ready = '0;
        #1;
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL full_resume got %b want 1", src_ready); end
        step();
        src_valid = 1'b0;
        out_ready = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_flit[OW-1:0] !== {2'd0, 8'(i), 1'b1}) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, out_flit[OW-1:0], {2'd0, 8'(i), 1'b1}); end
            step();
        end
        out_ready = '0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL full_drained got %b want 0000", out_valid); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        src_valid = 1'b1;
        src_flit  = mk(2, 3, 0, 1);
        step();
        src_flit  = mk(1, 0, 8'h01, 0);
        step();
        src_flit  = mk(1, 0, 8'h02, 0);
        step();
        src_valid = 1'b0;
        checks++; if (out_valid !== 4'b0010 || drop_count !== 8'd1) begin errors++; $display("FAIL mid_setup got %b/%0d want 0010/1", out_valid, drop_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b want 0000", out_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_rst_drop got %0d want 0", drop_count); end
        src_flit  = mk(0, 0, 8'h5A, 1);
        src_valid = 1'b1;
        #1;
        step();
        src_valid = 1'b0;
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL mid_new_route got %b want 0001", out_valid); end
        checks++; if (out_flit[OW-1:0] !== {2'd0, 8'h5A, 1'b1}) begin errors++; $display("FAIL mid_new_flit got %h", out_flit[OW-1:0]); end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        src_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            src_flit = mk($urandom_range(0, 3), 3, $urandom_range(0, 255), 1);
            step();
            if (i == 253) begin
                checks++; if (drop_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", drop_count); end
            end
            if (i == 254) begin
                checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", drop_count); end
            end
        end
        src_valid = 1'b0;
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", drop_count); end
    endtask

    task automatic test_random();
        logic [NP-1:0] ev;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            src_valid = ($urandom_range(0, 9) < 7);
            src_flit  = mk($urandom_range(0, 3),
                           ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                           $urandom_range(0, 255),
                           ($urandom_range(0, 2) == 0));
            out_ready = (cyc >= 2900) ? 4'hF : 4'($urandom_range(0, 15));
            #1;
            ev = model_vld();
            checks++; if (src_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, src_ready, model_ready()); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid, ev); end
            for (int i = 0; i < NP; i++) begin
                if (ev[i]) begin
                    checks++; if (out_flit[i*OW +: OW] !== mq[i][0]) begin errors++; $display("FAIL rnd_flit cyc %0d port %0d got %h want %h", cyc, i, out_flit[i*OW +: OW], mq[i][0]); end
                end
            end
            checks++; if (invalid_packet !== m_inv) begin errors++; $display("FAIL rnd_inv cyc %0d got %b want %b", cyc, invalid_packet, m_inv); end
            checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", cyc, drop_count, m_drop); end
            if (cyc >= 2900) src_valid = 1'b0;
            step();
        end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rnd_drain got %b want 0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_wormhole();
        test_invalid_drop();
        test_full_backpressure();
        test_reset_mid_packet();
        test_drop_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
